// File: rtl/reg_wb_ctrl_pkg.sv
// rtl/reg_wb_ctrl_pkg.sv - shared write-back widths and queue entry type
package reg_wb_ctrl_pkg;
   localparam int WB_ADDR_W   = 5;
   localparam int WB_DATA_W   = 32;
   localparam int WB_NUM_REGS = 18;
   localparam int WB_DEPTH    = 4;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] dest;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/reg_wb_ctrl_wb_fifo.sv
// rtl/reg_wb_ctrl_wb_fifo.sv - circular write-back queue, two pushes and one pop per cycle
module wb_fifo
   import reg_wb_ctrl_pkg::*;
#(
   parameter int DEPTH  = WB_DEPTH,
   parameter int ADDR_W = WB_ADDR_W,
   parameter int DATA_W = WB_DATA_W,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push0,
   input  logic [ADDR_W-1:0]              dest0,
   input  logic [DATA_W-1:0]              data0,
   input  logic                           push1,
   input  logic [ADDR_W-1:0]              dest1,
   input  logic [DATA_W-1:0]              data1,
   input  logic                           pop,
   output logic [CW-1:0]                  count,
   output logic [ADDR_W-1:0]              head_dest,
   output logic [DATA_W-1:0]              head_data,
   output logic [DEPTH-1:0]               ent_valid,
   output logic [DEPTH-1:0][ADDR_W-1:0]   ent_dest
);
   logic [ADDR_W-1:0]          dest_q [DEPTH];
   logic [DATA_W-1:0]          data_q [DEPTH];
   logic [PW-1:0]              rd_ptr, wr_ptr, wr_ptr1;
   logic [DEPTH-1:0][PW-1:0]   off;

   assign wr_ptr1   = wr_ptr + PW'(1);
   assign head_dest = dest_q[rd_ptr];
   assign head_data = data_q[rd_ptr];

   // push0 always lands in the lower slot so its write issues first
   always_ff @(posedge clk) begin
      if (push0) begin
         dest_q[wr_ptr] <= dest0;
         data_q[wr_ptr] <= data0;
         if (push1) begin
            dest_q[wr_ptr1] <= dest1;
            data_q[wr_ptr1] <= data1;
         end
      end else if (push1) begin
         dest_q[wr_ptr] <= dest1;
         data_q[wr_ptr] <= data1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + PW'(pop);
         wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
         count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
      end
   end

   // slot i is live when its distance from the head is below count
   always_comb begin
      off       = '0;
      ent_valid = '0;
      ent_dest  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off[i]       = PW'(i) - rd_ptr;
         ent_valid[i] = CW'(off[i]) < count;
         ent_dest[i]  = dest_q[i];
      end
   end
endmodule

// File: rtl/reg_wb_ctrl.sv
// rtl/reg_wb_ctrl.sv - register bank write-back arbiter, queue drain and RAW pending mask
module reg_wb_ctrl
   import reg_wb_ctrl_pkg::*;
#(
   parameter int DEPTH    = WB_DEPTH,
   parameter int DATA_W   = WB_DATA_W,
   parameter int ADDR_W   = WB_ADDR_W,
   parameter int NUM_REGS = WB_NUM_REGS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mem_valid,
   input  logic [ADDR_W-1:0]   mem_dest,
   input  logic [DATA_W-1:0]   mem_data,
   output logic                mem_ready,
   input  logic                alu_valid,
   input  logic [ADDR_W-1:0]   alu_dest,
   input  logic [DATA_W-1:0]   alu_data,
   output logic                alu_ready,
   output logic [ADDR_W-1:0]   DEST_REG,
   output logic [DATA_W-1:0]   WRT_DATA,
   output logic                WRT_EN,
   output logic [NUM_REGS-1:0] pend_mask,
   output logic                err
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [CW-1:0]                count, free;
   logic [ADDR_W-1:0]            head_dest;
   logic [DATA_W-1:0]            head_data;
   logic [DEPTH-1:0]             ent_valid;
   logic [DEPTH-1:0][ADDR_W-1:0] ent_dest;
   logic                         mem_fire, alu_fire, mem_ok, alu_ok;

   // the head leaving this cycle frees its slot for an incoming request
   assign free      = CW'(DEPTH) - count + CW'(count != '0);
   assign mem_ready = free >= CW'(1);
   assign alu_ready = free >= (mem_valid ? CW'(2) : CW'(1));

   assign mem_fire = mem_valid & mem_ready;
   assign alu_fire = alu_valid & alu_ready;
   assign mem_ok   = {1'b0, mem_dest} < (ADDR_W+1)'(NUM_REGS);
   assign alu_ok   = {1'b0, alu_dest} < (ADDR_W+1)'(NUM_REGS);

   assign WRT_EN   = count != '0;
   assign DEST_REG = WRT_EN ? head_dest : '0;
   assign WRT_DATA = WRT_EN ? head_data : '0;

   wb_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push0     (mem_fire & mem_ok),
      .dest0     (mem_dest),
      .data0     (mem_data),
      .push1     (alu_fire & alu_ok),
      .dest1     (alu_dest),
      .data1     (alu_data),
      .pop       (WRT_EN),
      .count     (count),
      .head_dest (head_dest),
      .head_data (head_data),
      .ent_valid (ent_valid),
      .ent_dest  (ent_dest)
   );

   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < DEPTH; i++)
         for (int r = 0; r < NUM_REGS; r++)
            if (ent_valid[i] && ent_dest[i] == ADDR_W'(r))
               pend_mask[r] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err <= 1'b0;
      else if ((mem_fire && !mem_ok) || (alu_fire && !alu_ok))
         err <= 1'b1;
   end
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// tb/tb_reg_wb_ctrl.sv - directed and randomized checks of reg_wb_ctrl against a queue model
module tb_reg_wb_ctrl;
   import reg_wb_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, alu_valid, mem_ready, alu_ready;
   logic [4:0]  mem_dest, alu_dest, DEST_REG;
   logic [31:0] mem_data, alu_data, WRT_DATA;
   logic        WRT_EN, err;
   logic [17:0] pend_mask;

   int checks = 0;
   int failures = 0;
   int wr_count = 0;
   int wr_snap;
   logic [31:0] dut_bank [18];
   logic [31:0] ref_bank [18];
   wb_entry_t   exp_q [$];
   logic        m_err;
   logic [4:0]  t_dest [4];
   logic [31:0] t_data [4];

   always #5 clk = ~clk;

   reg_wb_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .mem_valid (mem_valid),
      .mem_dest  (mem_dest),
      .mem_data  (mem_data),
      .mem_ready (mem_ready),
      .alu_valid (alu_valid),
      .alu_dest  (alu_dest),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .DEST_REG  (DEST_REG),
      .WRT_DATA  (WRT_DATA),
      .WRT_EN    (WRT_EN),
      .pend_mask (pend_mask),
      .err       (err)
   );

   // stand-in for the register bank: captures every write the controller issues
   always @(posedge clk) begin
      if (WRT_EN === 1'b1) begin
         wr_count = wr_count + 1;
         if (DEST_REG < 5'd18) dut_bank[DEST_REG] = WRT_DATA;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock: compare against the model, take the edge, update the model
   task automatic step();
      int free;
      logic mr, ar;
      logic [17:0] pm;
      wb_entry_t e;
      #1;
      free = 4 - exp_q.size() + ((exp_q.size() > 0) ? 1 : 0);
      mr = (free >= 1);
      ar = (free >= (mem_valid ? 2 : 1));
      chk("m_mem_ready", mem_ready, mr);
      chk("m_alu_ready", alu_ready, ar);
      if (exp_q.size() > 0) begin
         chk("m_wrt_en", WRT_EN, 1);
         chk("m_dest_reg", DEST_REG, exp_q[0].dest);
         chk("m_wrt_data", WRT_DATA, exp_q[0].data);
      end else begin
         chk("m_wrt_en_idle", WRT_EN, 0);
         chk("m_dest_idle", DEST_REG, 0);
         chk("m_data_idle", WRT_DATA, 0);
      end
      pm = '0;
      foreach (exp_q[i]) pm[exp_q[i].dest] = 1'b1;
      chk("m_pend_mask", pend_mask, pm);
      chk("m_err", err, m_err);
      @(posedge clk);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         ref_bank[e.dest] = e.data;
      end
      if (mem_valid && mr) begin
         if (mem_dest < 5'd18) exp_q.push_back('{dest: mem_dest, data: mem_data});
         else m_err = 1'b1;
      end
      if (alu_valid && ar) begin
         if (alu_dest < 5'd18) exp_q.push_back('{dest: alu_dest, data: alu_data});
         else m_err = 1'b1;
      end
      #1;
   endtask

   initial begin
      for (int i = 0; i < 18; i++) begin
         dut_bank[i] = '0;
         ref_bank[i] = '0;
      end
      m_err = 1'b0;
      rst = 1'b1;
      mem_valid = 0; mem_dest = 0; mem_data = 0;
      alu_valid = 0; alu_dest = 0; alu_data = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rst_wrt_en", WRT_EN, 0);
      chk("rst_dest_reg", DEST_REG, 0);
      chk("rst_wrt_data", WRT_DATA, 0);
      chk("rst_pend_mask", pend_mask, 0);
      chk("rst_mem_ready", mem_ready, 1);
      chk("rst_alu_ready", alu_ready, 1);
      chk("rst_err", err, 0);

      // single ALU write
      alu_valid = 1; alu_dest = 5; alu_data = 32'hDEADBEEF;
      step();
      alu_valid = 0;
      chk("single_wrt_en", WRT_EN, 1);
      chk("single_dest", DEST_REG, 5);
      chk("single_data", WRT_DATA, 32'hDEADBEEF);
      chk("single_pend", pend_mask, 18'h00020);
      step();
      chk("single_done_en", WRT_EN, 0);
      chk("single_done_pend", pend_mask, 0);
      chk("single_bank5", dut_bank[5], 32'hDEADBEEF);

      // simultaneous MEM and ALU to the same register
      mem_valid = 1; mem_dest = 3; mem_data = 32'h11;
      alu_valid = 1; alu_dest = 3; alu_data = 32'h22;
      #1;
      chk("dual_mem_ready", mem_ready, 1);
      chk("dual_alu_ready", alu_ready, 1);
      step();
      mem_valid = 0; alu_valid = 0;
      chk("dual_first", WRT_DATA, 32'h11);
      chk("dual_first_pend", pend_mask, 18'h00008);
      step();
      chk("dual_second", WRT_DATA, 32'h22);
      chk("dual_second_dest", DEST_REG, 3);
      step();
      chk("dual_idle", WRT_EN, 0);
      chk("dual_bank3", dut_bank[3], 32'h22);

      // fill to full while MEM stays valid
      mem_valid = 1; mem_dest = 1; mem_data = 32'h100;
      alu_valid = 1; alu_dest = 6; alu_data = 32'h200;
      #1 chk("fill_a_alu_ready", alu_ready, 1);
      step();
      mem_dest = 2; mem_data = 32'h101; alu_dest = 7; alu_data = 32'h201;
      #1 chk("fill_b_alu_ready", alu_ready, 1);
      step();
      mem_dest = 3; mem_data = 32'h102; alu_dest = 8; alu_data = 32'h202;
      #1 chk("fill_c_alu_ready", alu_ready, 1);
      step();
      mem_dest = 4; mem_data = 32'h103; alu_dest = 9; alu_data = 32'h203;
      #1;
      chk("full_alu_ready", alu_ready, 0);
      chk("full_mem_ready", mem_ready, 1);
      chk("full_pend", pend_mask, 18'h0018C);
      step();
      mem_valid = 0;
      #1 chk("full_alu_alone", alu_ready, 1);
      step();
      alu_valid = 0;
      t_dest = '{5'd3, 5'd8, 5'd4, 5'd9};
      t_data = '{32'h102, 32'h202, 32'h103, 32'h203};
      for (int k = 0; k < 4; k++) begin
         chk("drain_dest", DEST_REG, t_dest[k]);
         chk("drain_data", WRT_DATA, t_data[k]);
         step();
      end
      chk("drain_idle", WRT_EN, 0);

      // out-of-range destination
      alu_valid = 1; alu_dest = 20; alu_data = 32'h55;
      #1 chk("oor_alu_ready", alu_ready, 1);
      step();
      alu_valid = 0;
      chk("oor_no_write", WRT_EN, 0);
      chk("oor_err", err, 1);
      chk("oor_pend", pend_mask, 0);
      step();
      chk("oor_err_sticky", err, 1);

      // random dual-source traffic
      for (int c = 0; c < 100; c++) begin
         mem_valid = 1'($urandom_range(0, 1));
         alu_valid = 1'($urandom_range(0, 1));
         mem_dest  = 5'($urandom_range(0, 17));
         alu_dest  = 5'($urandom_range(0, 17));
         mem_data  = $urandom;
         alu_data  = $urandom;
         step();
      end
      mem_valid = 0; alu_valid = 0;
      repeat (6) step();
      chk("rand_err_sticky", err, 1);
      for (int r = 0; r < 18; r++) chk("bank_compare", dut_bank[r], ref_bank[r]);

      // reset with three writes queued
      mem_valid = 1; mem_dest = 10; mem_data = 32'hA0;
      alu_valid = 1; alu_dest = 11; alu_data = 32'hA1;
      step();
      mem_dest = 12; mem_data = 32'hA2; alu_dest = 13; alu_data = 32'hA3;
      step();
      mem_valid = 0; alu_valid = 0;
      #1 chk("pre_rst_pend", pend_mask, 18'h03800);
      #2 rst = 1'b1;
      #1;
      chk("midrst_wrt_en", WRT_EN, 0);
      chk("midrst_pend", pend_mask, 0);
      chk("midrst_dest", DEST_REG, 0);
      chk("midrst_err", err, 0);
      exp_q.delete();
      m_err = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      wr_snap = wr_count;
      repeat (3) step();
      chk("post_rst_no_writes", wr_count, wr_snap);
      chk("post_rst_alu_ready", alu_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
